adder_bist_ctrl: RTL and testbench
==================================

Name: adder_bist_ctrl

Overview:
- Synthesizable stimulus generator and response checker for the n-bit adders (csa, cra, cla, a1csa).
- It produces the a/b/cin vectors that the file-reading testbench stimulus otherwise supplies, and compares the DUV s/cout against an internal reference sum.
- It replaces the file-based in/out/comp trio for on-FPGA and gate-level self-test runs.
- It reports pass/fail, error count and the index of the first failing vector.

Parameters:
- n, 64, adder operand width (4..64).
- num_vectors, 30000, total vectors applied per run (≥5), corner vectors included.
- lat, 0, DUV result latency in clock cycles (0..4); 0 means purely combinational DUV.
- seed_a, 64'h0123456789ABCDEF, LFSR seed for a; only the low n bits are used.
- seed_b, 64'hFEDCBA9876543210, LFSR seed for b; only the low n bits are used.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  start a run; sampled only in IDLE or DONE.
- a  output  n  operand a to the DUV.
- b  output  n  operand b to the DUV.
- cin  output  1  carry-in to the DUV.
- s_duv  input  n  DUV sum.
- cout_duv  input  1  DUV carry-out.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE.
- pass  output  1  valid while done=1; 1 when err_count==0.
- err_count  output  16  mismatching vectors, saturates at 16'hFFFF.
- vec_count  output  16  vectors issued in the current run.
- first_err  output  16  index of the first mismatching vector; 16'hFFFF when there is none.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values (rst_n=0 at a rising edge):
  - FSM goes to IDLE.
  - a=0, b=0, cin=0, busy=0, done=0, pass=0, err_count=0, vec_count=0, first_err=16'hFFFF.
  - LFSRs load their seeds; a zero seed is replaced by 1.
  - The compare pipeline is cleared, all valid bits = 0.
- FSM states IDLE, RUN, DRAIN, DONE.
  - IDLE: on start=1, clear all counters, set first_err=16'hFFFF, reload the seeds, go to RUN.
  - RUN: issue one vector per cycle, vector k is on a/b/cin during cycle k. When vec_count reaches num_vectors, go to DRAIN.
  - DRAIN: stays lat cycles (0 cycles when lat=0) so the remaining compares finish. a/b/cin hold the last vector.
  - DONE: done=1 and pass is valid. start=1 restarts the run exactly as from IDLE.
- Vector sequence:
  - k=0: a=0, b=0, cin=0.
  - k=1: a=all-ones, b=0, cin=1 (full carry chain).
  - k=2: a=all-ones, b=all-ones, cin=1.
  - k=3: a=0x…5555, b=0x…AAAA, cin=1.
  - k≥4: a and b come from independent n-bit Galois LFSRs, each stepping once per vector; cin = bit 0 of the a LFSR XOR bit 0 of the b LFSR.
- Reference model: exp = a + b + cin, computed n+1 bits wide.
- Compare pipeline:
  - exp, the vector index and a valid bit are delayed lat stages.
  - The compare for vector k happens in cycle k+lat, against {cout_duv, s_duv}.
  - lat=0 compares in the same cycle combinationally and registers the result.
- Mismatch on a valid stage:
  - err_count increments, saturating at 16'hFFFF.
  - If first_err==16'hFFFF, load the index of that vector into first_err.
- pass is registered on entry to DONE.
- Boundary conditions:
  - start while in RUN or DRAIN is ignored.
  - rst_n low mid-run aborts the run immediately with reset values; no partial status is retained.
  - vec_count stops at num_vectors and does not wrap.
  - The LFSR period exceeds num_vectors for n≥16.

Test Plan:
- Correct combinational adder, lat=0, n=64, num_vectors=30000, then start pulse:
  - busy for 30000 cycles.
  - done=1, pass=1, err_count=0, first_err=16'hFFFF.
- DUV with cout stuck at 0, n=8, num_vectors=16:
  - first_err=1 (vector 1 is all-ones+1 with cout=1).
  - err_count equals the number of vectors whose reference carry-out is 1.
  - pass=0.
- Correct adder behind 3 register stages, lat=3:
  - pass=1.
  - busy lasts num_vectors+3 cycles.
  - If that same DUV is run with lat=2, err_count>0.
- rst_n low for 1 cycle at vector 100 of a run:
  - next cycle all outputs are at reset values and state is IDLE.
  - A new start reproduces vectors 0..3 exactly.
- DUV with s[0] forced to 1, lat=0:
  - first_err=0 and err_count>0.
  - A restart from DONE with a correct DUV gives err_count=0 and first_err=16'hFFFF.
- Same seeds across two runs:
  - identical a/b/cin sequence, checked cycle by cycle on the first 100 vectors.

Source files
------------

// File: rtl/adder_bist_ctrl.sv
// Self-test driver/checker for n-bit adders: corner vectors then Galois LFSR operands, one per cycle.
// Each result is compared lat cycles after its vector is applied; no backpressure, status is registered.
module adder_bist_ctrl #(
  parameter int          n           = 64,
  parameter int          num_vectors = 30000,
  parameter int          lat         = 0,
  parameter logic [63:0] seed_a      = 64'h0123456789ABCDEF,
  parameter logic [63:0] seed_b      = 64'hFEDCBA9876543210
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [n-1:0]  a,
  output logic [n-1:0]  b,
  output logic          cin,
  input  logic [n-1:0]  s_duv,
  input  logic          cout_duv,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [15:0]   vec_count,
  output logic [15:0]   first_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [63:0] tap(input int t);
    return 64'd1 << (t - 1);
  endfunction

  // Maximal-length feedback taps for each supported width.
  function automatic logic [63:0] poly(input int w);
    logic [63:0] m;
    case (w)
      4:  m = tap(4) | tap(3);                      5:  m = tap(5) | tap(3);
      6:  m = tap(6) | tap(5);                      7:  m = tap(7) | tap(6);
      8:  m = tap(8) | tap(6) | tap(5) | tap(4);    9:  m = tap(9) | tap(5);
      10: m = tap(10) | tap(7);                     11: m = tap(11) | tap(9);
      12: m = tap(12) | tap(6) | tap(4) | tap(1);   13: m = tap(13) | tap(4) | tap(3) | tap(1);
      14: m = tap(14) | tap(5) | tap(3) | tap(1);   15: m = tap(15) | tap(14);
      16: m = tap(16) | tap(15) | tap(13) | tap(4); 17: m = tap(17) | tap(14);
      18: m = tap(18) | tap(11);                    19: m = tap(19) | tap(6) | tap(2) | tap(1);
      20: m = tap(20) | tap(17);                    21: m = tap(21) | tap(19);
      22: m = tap(22) | tap(21);                    23: m = tap(23) | tap(18);
      24: m = tap(24) | tap(23) | tap(22) | tap(17); 25: m = tap(25) | tap(22);
      26: m = tap(26) | tap(6) | tap(2) | tap(1);   27: m = tap(27) | tap(5) | tap(2) | tap(1);
      28: m = tap(28) | tap(25);                    29: m = tap(29) | tap(27);
      30: m = tap(30) | tap(6) | tap(4) | tap(1);   31: m = tap(31) | tap(28);
      32: m = tap(32) | tap(22) | tap(2) | tap(1);  33: m = tap(33) | tap(20);
      34: m = tap(34) | tap(27) | tap(2) | tap(1);  35: m = tap(35) | tap(33);
      36: m = tap(36) | tap(25);
      37: m = tap(37) | tap(5) | tap(4) | tap(3) | tap(2) | tap(1);
      38: m = tap(38) | tap(6) | tap(5) | tap(1);   39: m = tap(39) | tap(35);
      40: m = tap(40) | tap(38) | tap(21) | tap(19); 41: m = tap(41) | tap(38);
      42: m = tap(42) | tap(41) | tap(20) | tap(19); 43: m = tap(43) | tap(42) | tap(38) | tap(37);
      44: m = tap(44) | tap(43) | tap(18) | tap(17); 45: m = tap(45) | tap(44) | tap(42) | tap(41);
      46: m = tap(46) | tap(45) | tap(26) | tap(25); 47: m = tap(47) | tap(42);
      48: m = tap(48) | tap(47) | tap(21) | tap(20); 49: m = tap(49) | tap(40);
      50: m = tap(50) | tap(49) | tap(24) | tap(23); 51: m = tap(51) | tap(50) | tap(36) | tap(35);
      52: m = tap(52) | tap(49);                    53: m = tap(53) | tap(52) | tap(38) | tap(37);
      54: m = tap(54) | tap(53) | tap(18) | tap(17); 55: m = tap(55) | tap(31);
      56: m = tap(56) | tap(55) | tap(35) | tap(34); 57: m = tap(57) | tap(50);
      58: m = tap(58) | tap(39);                    59: m = tap(59) | tap(58) | tap(38) | tap(37);
      60: m = tap(60) | tap(59);                    61: m = tap(61) | tap(60) | tap(46) | tap(45);
      62: m = tap(62) | tap(61) | tap(6) | tap(5);  63: m = tap(63) | tap(62);
      default: m = tap(64) | tap(63) | tap(61) | tap(60);
    endcase
    return m;
  endfunction

  localparam logic [63:0]  mask_full  = poly(n);
  localparam logic [n-1:0] mask       = mask_full[n-1:0];
  localparam logic [n-1:0] one_n      = {{(n-1){1'b0}}, 1'b1};
  localparam logic [n-1:0] seed_a_n   = (seed_a[n-1:0] == '0) ? one_n : seed_a[n-1:0];
  localparam logic [n-1:0] seed_b_n   = (seed_b[n-1:0] == '0) ? one_n : seed_b[n-1:0];
  localparam logic [63:0]  alt_full   = 64'h5555555555555555;
  localparam logic [n-1:0] alt5       = alt_full[n-1:0];
  localparam logic [15:0]  nv16       = 16'(num_vectors);
  localparam logic [2:0]   drain_last = (lat > 0) ? 3'(lat - 1) : 3'd0;

  function automatic logic [n-1:0] step(input logic [n-1:0] x);
    return x[0] ? ((x >> 1) ^ mask) : (x >> 1);
  endfunction

  state_t        state;
  logic [n-1:0]  lfsr_a, lfsr_b;
  logic [2:0]    drain_cnt;

  logic [n:0]    exp0, cmp_exp;
  logic [15:0]   idx0, cmp_idx;
  logic          vld0, cmp_vld, mism;
  logic [15:0]   err_nxt, first_nxt;

  assign exp0 = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};
  assign vld0 = (state == RUN);
  assign idx0 = vec_count - 16'd1;

  generate
    if (lat == 0) begin : g_comb
      assign cmp_exp = exp0;
      assign cmp_idx = idx0;
      assign cmp_vld = vld0;
    end else begin : g_pipe
      logic [n:0]  exp_q [lat];
      logic [15:0] idx_q [lat];
      logic        vld_q [lat];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < lat; i++) begin
            exp_q[i] <= '0;
            idx_q[i] <= '0;
            vld_q[i] <= 1'b0;
          end
        end else begin
          exp_q[0] <= exp0;
          idx_q[0] <= idx0;
          vld_q[0] <= vld0;
          for (int i = 1; i < lat; i++) begin
            exp_q[i] <= exp_q[i-1];
            idx_q[i] <= idx_q[i-1];
            vld_q[i] <= vld_q[i-1];
          end
        end
      end
      assign cmp_exp = exp_q[lat-1];
      assign cmp_idx = idx_q[lat-1];
      assign cmp_vld = vld_q[lat-1];
    end
  endgenerate

  assign mism = cmp_vld && ({cout_duv, s_duv} != cmp_exp);

  always_comb begin
    err_nxt   = err_count;
    first_nxt = first_err;
    if (mism) begin
      if (err_count != 16'hFFFF) err_nxt = err_count + 16'd1;
      if (first_err == 16'hFFFF) first_nxt = cmp_idx;
    end
  end

  // LFSRs advance only on LFSR-sourced vectors, so vector 4 carries the seeds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      cin       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_count <= '0;
      first_err <= 16'hFFFF;
      lfsr_a    <= seed_a_n;
      lfsr_b    <= seed_b_n;
      drain_cnt <= '0;
    end else begin
      err_count <= err_nxt;
      first_err <= first_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            first_err <= 16'hFFFF;
            vec_count <= 16'd1;
            a         <= '0;
            b         <= '0;
            cin       <= 1'b0;
            lfsr_a    <= seed_a_n;
            lfsr_b    <= seed_b_n;
            drain_cnt <= '0;
          end
        end
        RUN: begin
          if (vec_count == nv16) begin
            if (lat == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == 16'd0);
            end else begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            vec_count <= vec_count + 16'd1;
            case (vec_count)
              16'd1: begin a <= '1;    b <= '0;    cin <= 1'b1; end
              16'd2: begin a <= '1;    b <= '1;    cin <= 1'b1; end
              16'd3: begin a <= alt5;  b <= ~alt5; cin <= 1'b1; end
              default: begin
                a      <= lfsr_a;
                b      <= lfsr_b;
                cin    <= lfsr_a[0] ^ lfsr_b[0];
                lfsr_a <= step(lfsr_a);
                lfsr_b <= step(lfsr_b);
              end
            endcase
          end
        end
        DRAIN: begin
          if (drain_cnt == drain_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == 16'd0);
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Five controller instances, each driving its own bench-side adder (correct, faulty or pipelined)
// and checked every busy cycle against a vector-list model built from the sequence rules.
module tb_adder_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input int inst, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL u%0d.%s: got %0h expected %0h", inst, name, act, exp);
    end
  endtask

  // Per instance: width, vector count, controller latency, adder latency, fault (1 cout=0, 2 s[0]=1)
  localparam int GW [5] = '{64, 8, 16, 16, 8};
  localparam int GN [5] = '{30000, 16, 200, 200, 16};
  localparam int GL [5] = '{0, 0, 3, 2, 0};
  localparam int GD [5] = '{0, 0, 3, 3, 0};
  localparam int GF [5] = '{0, 1, 0, 0, 2};

  for (genvar g = 0; g < 5; g++) begin : u
    localparam int W  = GW[g];
    localparam int N  = GN[g];
    localparam int L  = GL[g];
    localparam int D  = GD[g];
    localparam int DI = (D > 0) ? D - 1 : 0;

    logic          rst_n, start, cin, cout_duv, busy, done, pass;
    logic [W-1:0]  a, b, s_duv;
    logic [15:0]   err_count, vec_count, first_err;
    logic [W:0]    raw, obs;
    logic [W:0]    dp [4];
    int            fault;
    bit            fin = 1'b0;

    logic [W-1:0]  ea [N];
    logic [W-1:0]  eb [N];
    logic          ec [N];

    adder_bist_ctrl #(.n(W), .num_vectors(N), .lat(L)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .s_duv(s_duv), .cout_duv(cout_duv), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .vec_count(vec_count), .first_err(first_err)
    );

    assign raw = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    always @(posedge clk) begin
      dp[0] <= raw;
      dp[1] <= dp[0];
      dp[2] <= dp[1];
      dp[3] <= dp[2];
    end
    always_comb begin
      obs = (D == 0) ? raw : dp[DI];
      if (fault == 1) obs[W] = 1'b0;
      else if (fault == 2) obs[0] = 1'b1;
    end
    assign cout_duv = obs[W];
    assign s_duv    = obs[W-1:0];

    function automatic logic [W-1:0] gal(input logic [W-1:0] x, input logic [W-1:0] m);
      return x[0] ? ((x >> 1) ^ m) : (x >> 1);
    endfunction

    task automatic build();
      logic [63:0]  mk, sa, sb, five;
      logic [W-1:0] m, la, lb, p5;
      mk   = (W == 64) ? 64'hD800000000000000 : (W == 16) ? 64'h000000000000D008 : 64'h00000000000000B8;
      sa   = 64'h0123456789ABCDEF;
      sb   = 64'hFEDCBA9876543210;
      five = 64'h5555555555555555;
      m  = mk[W-1:0];
      la = sa[W-1:0];
      lb = sb[W-1:0];
      p5 = five[W-1:0];
      if (la == '0) la = 1;
      if (lb == '0) lb = 1;
      for (int k = 0; k < N; k++) begin
        case (k)
          0: begin ea[k] = '0; eb[k] = '0;  ec[k] = 1'b0; end
          1: begin ea[k] = '1; eb[k] = '0;  ec[k] = 1'b1; end
          2: begin ea[k] = '1; eb[k] = '1;  ec[k] = 1'b1; end
          3: begin ea[k] = p5; eb[k] = ~p5; ec[k] = 1'b1; end
          default: begin
            ea[k] = la; eb[k] = lb; ec[k] = la[0] ^ lb[0];
            la = gal(la, m);
            lb = gal(lb, m);
          end
        endcase
      end
    endtask

    function automatic logic [W:0] sum_of(input int k);
      return {1'b0, ea[k]} + {1'b0, eb[k]} + {{W{1'b0}}, ec[k]};
    endfunction

    // Vector k is checked against whatever the adder showed lat cycles later; before the run it saw zeros.
    task automatic expect_res(input int f, output int e_err, output int e_first);
      logic [W:0] o;
      e_err   = 0;
      e_first = 'hFFFF;
      for (int k = 0; k < N; k++) begin
        int j;
        j = k - (D - L);
        o = (j < 0) ? '0 : sum_of(j);
        if (f == 1) o[W] = 1'b0;
        else if (f == 2) o[0] = 1'b1;
        if (o != sum_of(k)) begin
          e_err++;
          if (e_first == 'hFFFF) e_first = k;
        end
      end
    endtask

    task automatic chk_reset(input string tag);
      check(g, {tag, ".a"}, a, 0);
      check(g, {tag, ".b"}, b, 0);
      check(g, {tag, ".cin"}, cin, 0);
      check(g, {tag, ".busy"}, busy, 0);
      check(g, {tag, ".done"}, done, 0);
      check(g, {tag, ".pass"}, pass, 0);
      check(g, {tag, ".err_count"}, err_count, 0);
      check(g, {tag, ".vec_count"}, vec_count, 0);
      check(g, {tag, ".first_err"}, first_err, 16'hFFFF);
    endtask

    task automatic run(input int f, input bit abort);
      int cyc, k, e_err, e_first;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (busy === 1'b1 && cyc < N + 10) begin
        k = int'(vec_count) - 1;
        check(g, "vec_count", vec_count, (cyc < N) ? cyc + 1 : N);
        if (k >= 0 && k < N) begin
          check(g, "a", a, ea[k]);
          check(g, "b", b, eb[k]);
          check(g, "cin", cin, ec[k]);
        end
        start = (g == 2 && (cyc == 50 || cyc == N + 1));
        if (abort && cyc == 100) begin
          start = 1'b0;
          rst_n = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1;
          chk_reset("abort");
          return;
        end
        @(posedge clk); #1;
        cyc++;
      end
      start = 1'b0;
      expect_res(f, e_err, e_first);
      check(g, "busy_cycles", cyc, N + L);
      check(g, "done", done, 1);
      check(g, "pass", pass, (e_err == 0));
      check(g, "err_count", err_count, e_err);
      check(g, "first_err", first_err, e_first);
      check(g, "vec_count_end", vec_count, N);
    endtask

    initial begin
      fault = GF[g];
      rst_n = 1'b0;
      start = 1'b0;
      build();
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      if (g == 1) begin
        check(g, "model_a4", ea[4], 'hEF);
        check(g, "model_b4", eb[4], 'h10);
        check(g, "model_c4", ec[4], 1);
        check(g, "model_a5", ea[5], 'hCF);
        check(g, "model_b5", eb[5], 'h08);
      end
      if (g == 2) run(0, 1'b0 | 1'b1);
      run(fault, 1'b0);
      if (g == 1) check(g, "first_err_lit", first_err, 1);
      if (g == 3) check(g, "err_nonzero", (err_count != 0), 1);
      if (g == 4) begin
        check(g, "first_err_lit", first_err, 0);
        check(g, "err_nonzero", (err_count != 0), 1);
        fault = 0;
        @(posedge clk); #1;
        run(0, 1'b0);
      end
      fin = 1'b1;
    end
  end

  initial begin
    fork
      wait (u[0].fin && u[1].fin && u[2].fin && u[3].fin && u[4].fin);
      begin
        repeat (80000) @(posedge clk);
        n_checks++;
        n_fail++;
        $display("FAIL timeout: runs still pending after 80000 cycles");
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
